// File: rtl/vram_console.sv
// vram_console: text-mode writer for a COLS x ROWS character VRAM.
// Accepts bytes on a valid/ready handshake and writes printable characters
// at a hardware cursor. It interprets CR, LF, BS and FF. Moving the row past
// the bottom wraps to row 0 and blanks that row, which gives a rolling console.
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   ch_valid/ch_data/ch_ready  byte input handshake
//   v_ada/v_cea/v_din      VRAM write port (address, enable, data)
//   cursor_col/cursor_row  current cursor position
module vram_console #(
  parameter int          COLS   = 60,
  parameter int          ROWS   = 17,
  parameter int          ADDR_W = 10,
  parameter logic [7:0]  BLANK  = 8'h20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ch_valid,
  input  logic [7:0]        ch_data,
  output logic              ch_ready,
  output logic [ADDR_W-1:0] v_ada,
  output logic              v_cea,
  output logic [7:0]        v_din,
  output logic [5:0]        cursor_col,
  output logic [4:0]        cursor_row
);

  typedef enum logic [1:0] {IDLE, WRITE, CLR_ROW, CLR_ALL} state_t;

  localparam logic [ADDR_W-1:0] COLS_A   = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ALL_LAST = ADDR_W'(COLS * ROWS - 1);
  localparam logic [5:0]        LAST_COL = 6'(COLS - 1);
  localparam logic [4:0]        LAST_ROW = 5'(ROWS - 1);

  state_t              state_q, state_d;
  logic                ready_q, ready_d;
  logic                cea_q, cea_d;
  logic [ADDR_W-1:0]   ada_q, ada_d;
  logic [7:0]          din_q, din_d;
  logic [5:0]          col_q, col_d;
  logic [4:0]          row_q, row_d;
  logic [ADDR_W-1:0]   base_q, base_d;   // row_q * COLS, kept incrementally
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                adv_q, adv_d;     // WRITE should advance the cursor (not BS)

  logic [4:0]          nl_row;
  logic [ADDR_W-1:0]   nl_base;

  always_comb begin
    if (row_q == LAST_ROW) begin
      nl_row  = '0;
      nl_base = '0;
    end else begin
      nl_row  = row_q + 5'd1;
      nl_base = base_q + COLS_A;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    cea_d   = cea_q;
    ada_d   = ada_q;
    din_d   = din_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    cnt_d   = cnt_q;
    adv_d   = adv_q;

    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        cea_d   = 1'b0;
        if (ch_valid && ready_q) begin
          case (ch_data)
            8'h0D: col_d = '0;
            8'h0A: begin
              col_d   = '0;
              row_d   = nl_row;
              base_d  = nl_base;
              state_d = CLR_ROW;
              ready_d = 1'b0;
              cea_d   = 1'b1;
              ada_d   = nl_base;
              din_d   = BLANK;
              cnt_d   = '0;
            end
            8'h08: begin
              if (col_q != '0) begin
                col_d   = col_q - 6'd1;
                state_d = WRITE;
                ready_d = 1'b0;
                cea_d   = 1'b1;
                ada_d   = base_q + ADDR_W'(col_q) - ADDR_W'(1);
                din_d   = BLANK;
                adv_d   = 1'b0;
              end
            end
            8'h0C: begin
              col_d   = '0;
              row_d   = '0;
              base_d  = '0;
              state_d = CLR_ALL;
              ready_d = 1'b0;
              cea_d   = 1'b1;
              ada_d   = '0;
              din_d   = BLANK;
              cnt_d   = '0;
            end
            default: begin
              if (ch_data >= 8'h20) begin
                state_d = WRITE;
                ready_d = 1'b0;
                cea_d   = 1'b1;
                ada_d   = base_q + ADDR_W'(col_q);
                din_d   = ch_data;
                adv_d   = 1'b1;
              end
            end
          endcase
        end
      end

      WRITE: begin
        if (adv_q && (col_q == LAST_COL)) begin
          col_d   = '0;
          row_d   = nl_row;
          base_d  = nl_base;
          state_d = CLR_ROW;
          cea_d   = 1'b1;
          ada_d   = nl_base;
          din_d   = BLANK;
          cnt_d   = '0;
        end else begin
          if (adv_q) col_d = col_q + 6'd1;
          state_d = IDLE;
          ready_d = 1'b1;
          cea_d   = 1'b0;
        end
      end

      CLR_ROW, CLR_ALL: begin
        if (cnt_q == ((state_q == CLR_ROW) ? ROW_LAST : ALL_LAST)) begin
          state_d = IDLE;
          ready_d = 1'b1;
          cea_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
          ada_d = ada_q + ADDR_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      cea_q   <= 1'b0;
      ada_q   <= '0;
      din_q   <= '0;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      cnt_q   <= '0;
      adv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      cea_q   <= cea_d;
      ada_q   <= ada_d;
      din_q   <= din_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
      adv_q   <= adv_d;
    end
  end

  assign ch_ready   = ready_q;
  assign v_cea      = cea_q;
  assign v_ada      = ada_q;
  assign v_din      = din_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_vram_console.sv
// tb_vram_console: randomized self-checking bench for vram_console.
// A cursor/screen model computes, per byte, the expected VRAM write list,
// the number of cycles ch_ready stays low and the resulting cursor.
module tb_vram_console;

  localparam int COLS = 60;
  localparam int ROWS = 17;
  localparam int CELLS = COLS * ROWS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ch_valid = 1'b0;
  logic [7:0] ch_data = '0;
  logic       ch_ready;
  logic [9:0] v_ada;
  logic       v_cea;
  logic [7:0] v_din;
  logic [5:0] cursor_col;
  logic [4:0] cursor_row;

  vram_console #(.COLS(COLS), .ROWS(ROWS), .ADDR_W(10), .BLANK(8'h20)) dut (
    .clk(clk), .rst(rst), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_ready(ch_ready), .v_ada(v_ada), .v_cea(v_cea), .v_din(v_din),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int m_col = 0;
  int m_row = 0;
  int exp_stall = 0;
  int exp_q[$];
  int obs_q[$];

  task automatic check(input string tag, input int got, input int expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, expv, expv);
    end
  endtask

  // Every VRAM write seen, packed as addr<<8 | data.
  always @(negedge clk) begin
    if (!rst && v_cea) obs_q.push_back((int'(v_ada) << 8) | int'(v_din));
  end

  task automatic model_newline();
    m_row = (m_row + 1) % ROWS;
    for (int i = 0; i < COLS; i++) exp_q.push_back(((m_row * COLS + i) << 8) | 32'h20);
    exp_stall += COLS;
  endtask

  task automatic model_byte(input logic [7:0] b);
    exp_stall = 0;
    if (b == 8'h0D) begin
      m_col = 0;
    end else if (b == 8'h0A) begin
      m_col = 0;
      model_newline();
    end else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        exp_q.push_back(((m_row * COLS + m_col) << 8) | 32'h20);
        exp_stall = 1;
      end
    end else if (b == 8'h0C) begin
      m_col = 0;
      m_row = 0;
      for (int i = 0; i < CELLS; i++) exp_q.push_back((i << 8) | 32'h20);
      exp_stall = CELLS;
    end else if (b >= 8'h20) begin
      exp_q.push_back(((m_row * COLS + m_col) << 8) | int'(b));
      exp_stall = 1;
      m_col++;
      if (m_col == COLS) begin
        m_col = 0;
        model_newline();
      end
    end
  endtask

  task automatic xfer(input logic [7:0] b);
    int n;
    n = 0;
    while (!ch_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", int'(ch_ready), 1);
    ch_valid = 1'b1;
    ch_data  = b;
    @(posedge clk);
    #1;
    ch_valid = 1'b0;
    ch_data  = $urandom_range(0, 255);
    model_byte(b);
  endtask

  task automatic settle();
    int stall;
    int n;
    stall = 0;
    @(negedge clk);
    while (!ch_ready && stall < 3000) begin
      stall++;
      @(negedge clk);
    end
    check("stall", stall, exp_stall);
    check("nwrites", obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check("write", obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    check("col", int'(cursor_col), m_col);
    check("row", int'(cursor_row), m_row);
  endtask

  task automatic send(input logic [7:0] b);
    xfer(b);
    settle();
  endtask

  logic [7:0] rb;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", int'(ch_ready), 0);
    check("rst_cea", int'(v_cea), 0);
    check("rst_ada", int'(v_ada), 0);
    check("rst_din", int'(v_din), 0);
    check("rst_col", int'(cursor_col), 0);
    check("rst_row", int'(cursor_row), 0);
    rst = 1'b0;
    #1 check("ready_before_edge", int'(ch_ready), 0);
    @(negedge clk);
    check("ready_after_edge", int'(ch_ready), 1);

    // Two printable characters
    send(8'h41);
    send(8'h42);

    // Full row of X from column 0 wraps into a row-1 blank
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'h58);

    // Walk to row 16 col 5, then LF wraps to row 0
    while (m_row != ROWS - 1) send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h2E);
    send(8'h0A);

    // BS behaviour
    for (int i = 0; i < 3; i++) send(8'h61);
    send(8'h5A);
    send(8'h08);
    send(8'h0D);
    send(8'h08);

    // Full clear and an ignored control
    send(8'h0C);
    send(8'h07);

    // Random byte stream
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      rb = 8'($urandom_range(32, 255));
      else if (r < 78) rb = 8'h0D;
      else if (r < 84) rb = 8'h0A;
      else if (r < 94) rb = 8'h08;
      else begin
        rb = 8'($urandom_range(0, 31));
        if (rb == 8'h0C) rb = 8'h01;
      end
      send(rb);
    end

    // Reset in the middle of a full clear
    xfer(8'h0C);
    repeat (100) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_cea", int'(v_cea), 0);
    check("midrst_col", int'(cursor_col), 0);
    check("midrst_row", int'(cursor_row), 0);
    check("midrst_ready", int'(ch_ready), 0);
    obs_q.delete();
    exp_q.delete();
    m_col = 0;
    m_row = 0;
    @(negedge clk);
    rst = 1'b0;
    #1 check("rel_ready_low", int'(ch_ready), 0);
    @(negedge clk);
    check("rel_ready_high", int'(ch_ready), 1);
    send(8'h51);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
